irq_request_unit: RTL and testbench
===================================

// Module: irq_request_unit
// PURPOSE
//  - Upstream interrupt front-end for the multi-cycle controller FSM.
//  - Edge-detects the keyboard and counter IRQ sources, holds them pending, and applies the CP0 mask.
//  - Drives INT_KBD/INT_CNT only while the controller is in IF, then tracks the acknowledge/service/return handshake.
//  - Exports the latched cause code to the CP0 write path.
// PARAMETERS
//  STATE_W     5      width of controller state bus
//  SYNC_STAGES 2      flops in raw-input synchroniser (used only with IRQ_SYNC_EN)
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high reset
//  kbd_irq     in   1        raw keyboard ready level
//  cnt_irq     in   1        raw counter-overflow level
//  state_in    in   STATE_W  controller state_out
//  mask_we     in   1        write strobe for mask register
//  mask_wdata  in   2        [0]=KBD enable, [1]=CNT enable (1 = enabled)
//  INT_KBD     out  1        keyboard request to controller
//  INT_CNT     out  1        counter request to controller
//  cause_code  out  3        cause of the interrupt in service (KBD=3'd0, CNT=3'd4)
//  pending     out  2        pending bits {CNT,KBD}
//  in_service  out  1        high from acceptance until return
// BEHAVIOUR
//  - Reset: pending=0, mask=2'b11, cause_code=0, in_service=0, INT_*=0, FSM=IDLE, edge history=0.
//  - Edge detect: pending[i] sets on the 0->1 transition of the (optionally synchronised) source, one cycle after it is sampled.
//  - Levels held high do not re-trigger.
//  - mask_we: mask <= mask_wdata on the next edge. Masked pending bits are kept, not dropped.
//  - Request: eligible = pending & mask; winner = KBD if eligible[0], else CNT.
//  - INT_KBD/INT_CNT are combinational: winner & (FSM==ARMED) & (state_in==ST_IF).
//    - Both are forced 0 in every other state_in. The controller stalls if a request is seen outside IF.
//  - drove_q: registered copy of (INT_KBD|INT_CNT), with the winner id latched alongside it.
//  - FSM:
//    - IDLE    -> ARMED    when |eligible.
//    - ARMED   -> SERVICE  when drove_q && state_in==ST_INT_WEPC.
//      - On this edge: clear pending[winner_q], set cause_code, set in_service=1.
//    - ARMED   -> IDLE     when eligible becomes 0 through a mask write.
//    - SERVICE -> IDLE     when state_in==ST_INT_RET, which clears in_service.
//    - SERVICE never drives requests, so there is no nesting. New edges still set pending.
//  - Entry to ST_INT_WEPC without drove_q (syscall/unimpl/overflow) is not accepted: FSM and pending unchanged.
//  - Simultaneous new edge and clear of the same bit: set wins, and the bit stays pending.
//  - Latency: with the sync disabled, a raw edge at cycle n gives pending at n+1, and INT_* at n+1 if state_in==IF.
//  - Reset mid-service returns everything to reset values, and pending is lost.
// CONFIGURATION
//  - IRQ_SYNC_EN defined:
//    - kbd_irq/cnt_irq pass through a SYNC_STAGES-flop synchroniser before edge detect.
//    - This adds SYNC_STAGES cycles of latency. Use it when the sources are asynchronous.
//  - IRQ_SYNC_EN undefined: raw inputs feed edge detect directly, and the sources must already be in the clk domain.
// STRUCTURE
//  - Shared header irq_defs.vh holds:
//    - controller state codes: ST_IF=5'h00, ST_INT_WEPC=5'h12, ST_INT_RET=5'h16
//    - cause codes: KBD=0, SYS=1, UNIMPL=2, OVF=3, CNT=4
//    - local FSM encodings IDLE/ARMED/SERVICE
//  - One sub-module, irq_edge_sync: per-source optional synchroniser plus rising-edge detector.
//    - Instantiated twice; outputs a single-cycle rise pulse.
// TESTING
//  - kbd_irq 0->1 with state_in=IF, mask=11:
//    - pending=01 and INT_KBD=1 next cycle.
//    - state_in=12h next cycle: in_service=1, cause_code=0, pending=00.
//  - kbd and cnt rise in the same cycle: INT_KBD first.
//    - After ST_INT_RET and a return to IF, INT_CNT=1 and cause_code=4 after acceptance.
//  - pending=01 while state_in=0Dh (WB_R): INT_*=0 for every cycle until state_in=00h, then INT_KBD=1.
//  - mask_wdata=2'b10, kbd edge: pending=01, INT_*=0, FSM stays IDLE.
//    - Writing mask=11 then raises INT_KBD at the next IF.
//  - state_in=12h with drove_q=0 (syscall): in_service stays 0, pending unchanged.
//  - reset asserted while in_service=1 with cnt pending: all outputs 0 on the next edge.
//    - With IRQ_SYNC_EN defined, check the edge->pending latency is 1+SYNC_STAGES cycles.

Source files
------------

// File: rtl/irq_request_unit_pkg.sv
// irq_request_unit_pkg: shared controller state codes, cause codes and local FSM encoding
// Optional feature macro: IRQ_SYNC_EN (consumed by irq_request_unit)
package irq_request_unit_pkg;
  typedef enum logic [4:0] {
    ST_IF       = 5'h00,
    ST_INT_WEPC = 5'h12,
    ST_INT_RET  = 5'h16
  } ctrl_state_t;
  typedef enum logic [2:0] {
    CAUSE_KBD    = 3'd0,
    CAUSE_SYS    = 3'd1,
    CAUSE_UNIMPL = 3'd2,
    CAUSE_OVF    = 3'd3,
    CAUSE_CNT    = 3'd4
  } cause_t;
  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SERVICE
  } irq_state_t;
  function automatic cause_t cause_of(input logic cnt_won);
    return cnt_won ? CAUSE_CNT : CAUSE_KBD;
  endfunction
endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: optional STAGES-flop synchroniser followed by a rising-edge detector
// Ports: clk, reset (sync, active-high), src (raw level), rise (one-cycle pulse on 0->1)
// STAGES=0 feeds src straight into the edge detector.
module irq_edge_sync #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic rise
);
  logic s;
  logic prev;
  generate
    if (STAGES > 0) begin : g_sync
      logic [STAGES-1:0] q;
      always_ff @(posedge clk) begin
        if (reset) q <= '0;
        else begin
          q[0] <= src;
          for (int i = 1; i < STAGES; i++) q[i] <= q[i-1];
        end
      end
      assign s = q[STAGES-1];
    end else begin : g_raw
      assign s = src;
    end
  endgenerate
  always_ff @(posedge clk) prev <= reset ? 1'b0 : s;
  assign rise = s & ~prev;
endmodule

// File: rtl/irq_request_unit.sv
// irq_request_unit: edge-detected KBD/CNT interrupt front-end with mask, IF-gated requests and service tracking
// Ports: clk, reset (sync, active-high), kbd_irq/cnt_irq (raw levels), state_in (controller state),
//   mask_we/mask_wdata ([0]=KBD,[1]=CNT enable), INT_KBD/INT_CNT (requests), cause_code,
//   pending {CNT,KBD}, in_service
// Define IRQ_SYNC_EN to put a SYNC_STAGES-flop synchroniser in front of each edge detector.
module irq_request_unit
  import irq_request_unit_pkg::*;
#(
  parameter int STATE_W     = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               kbd_irq,
  input  logic               cnt_irq,
  input  logic [STATE_W-1:0] state_in,
  input  logic               mask_we,
  input  logic [1:0]         mask_wdata,
  output logic               INT_KBD,
  output logic               INT_CNT,
  output logic [2:0]         cause_code,
  output logic [1:0]         pending,
  output logic               in_service
);
`ifdef IRQ_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  logic [1:0] mask, rise, eligible, clr, pending_n, mask_n;
  logic drove_q, winner_q, req, accept;
  irq_state_t fsm, fsm_n;
  irq_edge_sync #(.STAGES(SYNC_EN ? SYNC_STAGES : 0)) u_kbd (
    .clk(clk), .reset(reset), .src(kbd_irq), .rise(rise[0])
  );
  irq_edge_sync #(.STAGES(SYNC_EN ? SYNC_STAGES : 0)) u_cnt (
    .clk(clk), .reset(reset), .src(cnt_irq), .rise(rise[1])
  );
  // Arming looks at next-cycle pending/mask so a fresh edge requests in the same cycle it becomes pending.
  always_comb begin
    eligible   = pending & mask;
    req        = (fsm == ARMED) && (state_in == STATE_W'(ST_IF));
    INT_KBD    = req && eligible[0];
    INT_CNT    = req && !eligible[0] && eligible[1];
    accept     = (fsm == ARMED) && drove_q && (state_in == STATE_W'(ST_INT_WEPC));
    clr        = accept ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
    pending_n  = (pending & ~clr) | rise;
    mask_n     = mask_we ? mask_wdata : mask;
    fsm_n      = (fsm == SERVICE) ? ((state_in == STATE_W'(ST_INT_RET)) ? IDLE : SERVICE)
               : accept ? SERVICE
               : |(pending_n & mask_n) ? ARMED : IDLE;
    in_service = (fsm == SERVICE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      mask       <= 2'b11;
      cause_code <= CAUSE_KBD;
      fsm        <= IDLE;
      drove_q    <= 1'b0;
      winner_q   <= 1'b0;
    end else begin
      pending  <= pending_n;
      mask     <= mask_n;
      fsm      <= fsm_n;
      drove_q  <= INT_KBD | INT_CNT;
      winner_q <= INT_CNT;
      if (accept) cause_code <= cause_of(winner_q);
    end
  end
endmodule

// File: tb/tb_irq_request_unit.sv
// tb_irq_request_unit: directed vector table plus randomized run against a behavioural reference model
module tb_irq_request_unit;
  localparam int SYNC_STAGES = 2;
`ifdef IRQ_SYNC_EN
  localparam int LAT = SYNC_STAGES;
`else
  localparam int LAT = 0;
`endif
  localparam logic [4:0] S_IF = 5'h00, S_W = 5'h12, S_R = 5'h16, S_D = 5'h0D;
  logic clk = 1'b0, reset, kbd_irq, cnt_irq, mask_we;
  logic [4:0] state_in;
  logic [1:0] mask_wdata, pending;
  logic INT_KBD, INT_CNT, in_service;
  logic [2:0] cause_code;
  int checks = 0, failures = 0;
  irq_request_unit #(.STATE_W(5), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .kbd_irq(kbd_irq), .cnt_irq(cnt_irq), .state_in(state_in),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .INT_KBD(INT_KBD), .INT_CNT(INT_CNT),
    .cause_code(cause_code), .pending(pending), .in_service(in_service)
  );
  always #5 clk = ~clk;
  // Reference model: pending set of sources, an enable mask, and a "requests allowed" flag
  bit [1:0] m_pend, m_mask, m_prev;
  bit m_armed, m_svc, m_drove, m_did;
  bit [2:0] m_cause;
  bit [1:0] m_hist[$];
  function automatic bit [7:0] model_out(input logic [4:0] s);
    bit [1:0] elig, reqs;
    elig = m_pend & m_mask;
    reqs = 2'b00;
    if (m_armed && s == S_IF && elig != 0) reqs[elig[0] ? 0 : 1] = 1'b1;
    return {reqs, m_pend, m_svc, m_cause};
  endfunction
  function automatic void model_step(input bit r, input bit [1:0] raw, input logic [4:0] s,
                                     input bit we, input bit [1:0] wd);
    bit [1:0] src, rises, reqs;
    bit acc, was_svc;
    if (r) begin
      m_pend = 0; m_mask = 2'b11; m_prev = 0; m_armed = 0; m_svc = 0;
      m_drove = 0; m_did = 0; m_cause = 0;
      m_hist.delete();
      for (int i = 0; i < LAT; i++) m_hist.push_back(2'b00);
      return;
    end
    reqs = model_out(s) >> 6;
    m_hist.push_back(raw);
    src = m_hist.pop_front();
    rises = src & ~m_prev;
    m_prev = src;
    was_svc = m_svc;
    acc = m_armed && m_drove && s == S_W;
    if (acc) begin
      m_pend[m_did] = 1'b0;
      m_cause = m_did ? 3'd4 : 3'd0;
      m_svc = 1'b1;
    end
    m_pend |= rises;
    if (we) m_mask = wd;
    if (was_svc && s == S_R) m_svc = 1'b0;
    m_armed = !was_svc && !acc && ((m_pend & m_mask) != 0);
    m_drove = reqs != 0;
    m_did = reqs[1];
  endfunction
  function automatic bit [7:0] dut_out();
    return {INT_CNT, INT_KBD, pending, in_service, cause_code};
  endfunction
  task automatic cyc(input bit chk, input bit r, k, c, input logic [4:0] s, input bit we,
                     input bit [1:0] wd, input bit use_exp, input bit [7:0] exp, input string nm);
    bit [7:0] want;
    @(negedge clk);
    reset = r; kbd_irq = k; cnt_irq = c; state_in = s; mask_we = we; mask_wdata = wd;
    #1;
    if (chk) begin
      want = use_exp ? exp : model_out(s);
      checks++;
      if (dut_out() !== want) begin
        failures++;
        $display("FAIL %s {int,pend,svc,cause} got=%b want=%b", nm, dut_out(), want);
      end
    end
    @(posedge clk);
    model_step(r, {c, k}, s, we, wd);
  endtask
  typedef struct {
    bit r, k, c;
    logic [4:0] s;
    bit we;
    bit [1:0] wd;
    bit [7:0] exp;
  } vec_t;
  vec_t v[$];
  function automatic void add(input bit r, k, c, input logic [4:0] s, input bit we,
                              input bit [1:0] wd, input bit [1:0] i, p, input bit sv,
                              input bit [2:0] ca);
    v.push_back('{r, k, c, s, we, wd, {i, p, sv, ca}});
  endfunction
  initial begin
    int lat;
    logic [4:0] sp;
    bit r, k, c, we;
    reset = 1; kbd_irq = 0; cnt_irq = 0; state_in = S_IF; mask_we = 0; mask_wdata = 0;
    repeat (2) cyc(0, 1, 0, 0, S_IF, 0, 0, 0, 0, "");
`ifndef IRQ_SYNC_EN
    add(0,0,0,S_IF,0,0, 0,0,0,0); add(0,1,0,S_IF,0,0, 0,0,0,0); add(0,1,0,S_IF,0,0, 1,1,0,0);
    add(0,1,0,S_W ,0,0, 0,1,0,0); add(0,1,0,S_IF,0,0, 0,0,1,0); add(0,0,0,S_R ,0,0, 0,0,1,0);
    add(0,0,0,S_IF,0,0, 0,0,0,0); add(0,1,1,S_IF,0,0, 0,0,0,0); add(0,1,1,S_IF,0,0, 1,3,0,0);
    add(0,1,1,S_W ,0,0, 0,3,0,0); add(0,1,1,S_D ,0,0, 0,2,1,0); add(0,1,1,S_R ,0,0, 0,2,1,0);
    add(0,1,1,S_IF,0,0, 0,2,0,0); add(0,1,1,S_IF,0,0, 2,2,0,0); add(0,1,1,S_W ,0,0, 0,2,0,0);
    add(0,1,1,S_IF,0,0, 0,0,1,4); add(0,0,0,S_R ,0,0, 0,0,1,4); add(0,0,0,S_IF,0,0, 0,0,0,4);
    add(0,1,0,S_D ,0,0, 0,0,0,4); add(0,1,0,S_D ,0,0, 0,1,0,4); add(0,1,0,S_D ,0,0, 0,1,0,4);
    add(0,1,0,S_IF,0,0, 1,1,0,4); add(0,1,0,S_W ,0,0, 0,1,0,4); add(0,0,0,S_R ,0,0, 0,0,1,0);
    add(0,0,0,S_IF,0,0, 0,0,0,0); add(0,0,0,S_IF,1,2, 0,0,0,0); add(0,1,0,S_IF,0,0, 0,0,0,0);
    add(0,1,0,S_IF,0,0, 0,1,0,0); add(0,1,0,S_W ,0,0, 0,1,0,0); add(0,1,0,S_IF,1,3, 0,1,0,0);
    add(0,1,0,S_IF,0,0, 1,1,0,0); add(0,1,0,S_W ,0,0, 0,1,0,0); add(0,0,0,S_R ,0,0, 0,0,1,0);
    add(0,0,0,S_IF,0,0, 0,0,0,0); add(0,1,0,S_IF,0,0, 0,0,0,0); add(0,0,0,S_IF,0,0, 1,1,0,0);
    add(0,1,0,S_W ,0,0, 0,1,0,0); add(0,1,0,S_IF,0,0, 0,1,1,0); add(0,1,0,S_R ,0,0, 0,1,1,0);
    add(0,1,0,S_IF,0,0, 0,1,0,0); add(0,1,0,S_IF,0,0, 1,1,0,0); add(0,1,0,S_D ,1,0, 0,1,0,0);
    add(0,1,0,S_IF,0,0, 0,1,0,0); add(0,1,0,S_IF,1,3, 0,1,0,0); add(0,1,0,S_IF,0,0, 1,1,0,0);
    add(0,1,0,S_W ,0,0, 0,1,0,0); add(0,0,0,S_R ,0,0, 0,0,1,0); add(0,0,0,S_IF,0,0, 0,0,0,0);
    add(0,0,1,S_IF,0,0, 0,0,0,0); add(0,0,1,S_IF,0,0, 2,2,0,0); add(0,0,1,S_W ,0,0, 0,2,0,0);
    add(0,0,0,S_IF,0,0, 0,0,1,4); add(0,0,1,S_D ,0,0, 0,0,1,4); add(0,0,1,S_D ,0,0, 0,2,1,4);
    add(1,0,1,S_D ,0,0, 0,2,1,4); add(0,0,0,S_IF,0,0, 0,0,0,0);
    foreach (v[i])
      cyc(1, v[i].r, v[i].k, v[i].c, v[i].s, v[i].we, v[i].wd, 1, v[i].exp, $sformatf("vec[%0d]", i));
`else
    cyc(0, 1, 0, 0, S_D, 0, 0, 0, 0, "");
    lat = 0;
    do begin
      cyc(0, 0, 1, 0, S_D, 0, 0, 0, 0, "");
      lat++;
      #1;
    end while (pending[0] !== 1'b1 && lat < 10);
    checks++;
    if (lat != 1 + SYNC_STAGES) begin
      failures++;
      $display("FAIL sync_latency got=%0d want=%0d", lat, 1 + SYNC_STAGES);
    end
`endif
    for (int n = 0; n < 3000; n++) begin
      r  = $urandom_range(0, 199) == 0;
      k  = ($urandom_range(0, 5) == 0) ? !kbd_irq : kbd_irq;
      c  = ($urandom_range(0, 5) == 0) ? !cnt_irq : cnt_irq;
      we = $urandom_range(0, 19) == 0;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: sp = S_IF;
        4, 5:       sp = S_W;
        6:          sp = S_R;
        7, 8:       sp = S_D;
        default:    sp = 5'($urandom_range(0, 31));
      endcase
      cyc(1, r, k, c, sp, we, 2'($urandom_range(0, 3)), 0, 0, $sformatf("rand[%0d]", n));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
